mux_stream_rr: RTL and testbench

Parametrised N-channel, W-bit stream multiplexer with a registered output and valid/ready handshaking on every port. It is the successor to the team's fixed 2:1 4-bit combinational mux. It selects one of CHANNELS input streams per cycle, either by an external select (MODE 0) or by round-robin arbitration (MODE 1). It sits between multiple data producers and a single consumer and provides one-cycle registered latency at full throughput.

---
 rtl/mux_stream_rr_if.sv | 33 +++
 rtl/mux_stream_rr.sv | 99 +++++++++
 tb/tb_mux_stream_rr.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_stream_rr_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux_stream_rr_if
//  Description : Bundle of the N-input / 1-output stream ports of mux_stream_rr.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mux_stream_rr_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [SEL_W-1:0]          sel;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;

    // Producer/consumer side
    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    // Multiplexer side
    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/mux_stream_rr.sv
`default_nettype none
// ============================================================================
//  Module      : mux_stream_rr
//  Description : N-channel stream mux, external-select or round-robin grant,
//                single registered output stage with valid/ready handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_stream_rr #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int MODE     = 0,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  wire logic            clk,
    input  wire logic            rst,
    mux_stream_rr_if.slave       bus
);

    logic [CHANNELS-1:0] w_gnt;
    logic [SEL_W-1:0]    w_idx;
    logic [WIDTH-1:0]    w_mux_data;
    logic                w_load;
    logic                w_xfer;

    logic [WIDTH-1:0]    r_out_data;
    logic [SEL_W-1:0]    r_out_chan;
    logic                r_out_valid;

    assign w_load = ~r_out_valid | bus.out_ready;

    if (MODE == 0) begin : g_sel
        // Out-of-range select decodes to no grant at all.
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_dec
            assign w_gnt[gi] = (bus.sel == SEL_W'(gi));
        end
        assign w_idx = bus.sel;
    end else begin : g_rr
        logic [SEL_W-1:0] r_ptr;
        logic [SEL_W-1:0] w_cand;
        logic             w_found;

        // Scan ptr+1 .. ptr (wrapping); first valid channel wins.
        always_comb begin
            w_gnt   = '0;
            w_idx   = r_ptr;
            w_found = 1'b0;
            w_cand  = '0;
            for (int k = 1; k <= CHANNELS; k++) begin
                w_cand = SEL_W'((int'(r_ptr) + k) % CHANNELS);
                if (!w_found && bus.in_valid[w_cand]) begin
                    w_found       = 1'b1;
                    w_gnt[w_cand] = 1'b1;
                    w_idx         = w_cand;
                end
            end
        end

        // Pointer only advances on an accepted word, so stalls keep fairness.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_ptr <= SEL_W'(CHANNELS - 1);
            end else if (w_xfer) begin
                r_ptr <= w_idx;
            end
        end
    end

    always_comb begin
        w_mux_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_gnt[i]) begin
                w_mux_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_xfer       = w_load & (|(w_gnt & bus.in_valid));
    assign bus.in_ready = w_gnt & {CHANNELS{w_load}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
        end else if (w_load) begin
            r_out_valid <= w_xfer;
            if (w_xfer) begin
                r_out_data <= w_mux_data;
                r_out_chan <= w_idx;
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_chan  = r_out_chan;
    assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux_stream_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_stream_rr
//  Description : Scoreboard bench for mux_stream_rr (select, round-robin and
//                out-of-range-select instances sharing one stimulus).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_stream_rr;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] din  = 16'hDCBA;
    logic [3:0]  vld  = 4'h0;
    logic [1:0]  sel  = 2'd0;
    logic [1:0]  sel3 = 2'd3;
    logic        ordy = 1'b1;
    logic        mon_en = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // Expected output words {chan, data}, one queue per scoreboarded instance.
    logic [5:0] sbq0[$];
    logic [5:0] sbq1[$];
    logic [1:0] m_ptr = 2'd3;

    mux_stream_rr_if #(.WIDTH(4), .CHANNELS(4)) b0 ();
    mux_stream_rr_if #(.WIDTH(4), .CHANNELS(4)) b1 ();
    mux_stream_rr_if #(.WIDTH(4), .CHANNELS(3)) b3 ();

    assign b0.in_data = din;       assign b1.in_data = din;       assign b3.in_data = din[11:0];
    assign b0.in_valid = vld;      assign b1.in_valid = vld;      assign b3.in_valid = vld[2:0];
    assign b0.sel = sel;           assign b1.sel = sel;           assign b3.sel = sel3;
    assign b0.out_ready = ordy;    assign b1.out_ready = ordy;    assign b3.out_ready = ordy;

    mux_stream_rr #(.WIDTH(4), .CHANNELS(4), .MODE(0)) u_sel (.clk(clk), .rst(rst), .bus(b0));
    mux_stream_rr #(.WIDTH(4), .CHANNELS(4), .MODE(1)) u_rr  (.clk(clk), .rst(rst), .bus(b1));
    mux_stream_rr #(.WIDTH(4), .CHANNELS(3), .MODE(0)) u_c3  (.clk(clk), .rst(rst), .bus(b3));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_gnt(input bit rr, input logic [1:0] ptr,
                                             input logic [3:0] v, input logic [1:0] s);
        logic [3:0] g;
        logic [1:0] ix;
        g = 4'b0;
        if (!rr) begin
            g[s] = 1'b1;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                ix = ptr + k[1:0];
                if (g == 4'b0 && v[ix]) g[ix] = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) r = i[1:0];
        return r;
    endfunction

    task automatic model_edge();
        logic [3:0] g;
        logic       ld;
        logic [1:0] ix;
        ld = (sbq0.size() == 0) || ordy;
        g  = model_gnt(1'b0, m_ptr, vld, sel);
        ix = onehot_idx(g);
        if (sbq0.size() != 0 && ordy) void'(sbq0.pop_front());
        if (ld && (|(g & vld))) sbq0.push_back({ix, din[ix*4 +: 4]});

        ld = (sbq1.size() == 0) || ordy;
        g  = model_gnt(1'b1, m_ptr, vld, sel);
        ix = onehot_idx(g);
        if (sbq1.size() != 0 && ordy) void'(sbq1.pop_front());
        if (ld && (|(g & vld))) begin
            sbq1.push_back({ix, din[ix*4 +: 4]});
            m_ptr <= ix;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sbq0.delete();
            sbq1.delete();
            m_ptr <= 2'd3;
        end else begin
            model_edge();
        end
    end

    // Compare registered outputs and combinational ready against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("sel_valid", b0.out_valid, sbq0.size() != 0);
            if (sbq0.size() != 0) begin
                check_eq("sel_data", b0.out_data, sbq0[0][3:0]);
                check_eq("sel_chan", b0.out_chan, sbq0[0][5:4]);
            end
            check_eq("sel_in_ready", b0.in_ready,
                     model_gnt(1'b0, m_ptr, vld, sel) & {4{(sbq0.size() == 0) || ordy}});
            check_eq("rr_valid", b1.out_valid, sbq1.size() != 0);
            if (sbq1.size() != 0) begin
                check_eq("rr_data", b1.out_data, sbq1[0][3:0]);
                check_eq("rr_chan", b1.out_chan, sbq1[0][5:4]);
            end
            check_eq("rr_in_ready", b1.in_ready,
                     model_gnt(1'b1, m_ptr, vld, sel) & {4{(sbq1.size() == 0) || ordy}});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2 rst = 1'b1;
        #1 mon_en = 1'b1;
        tick();
        check_eq("rst_valid", {b0.out_valid, b1.out_valid, b3.out_valid}, 3'b000);
        check_eq("rst_data", {b0.out_data, b1.out_data, b3.out_data}, 12'h000);
        check_eq("rst_chan", {b0.out_chan, b1.out_chan, b3.out_chan}, 6'h00);
        rst = 1'b0;

        // Round-robin fairness straight out of reset: starts at channel 0.
        vld = 4'hF; ordy = 1'b1; sel = 2'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("rr_seq_chan", b1.out_chan, i % 4);
            check_eq("rr_seq_valid", b1.out_valid, 1'b1);
        end

        for (int i = 0; i < 4; i++) begin
            sel = i[1:0];
            tick();
            check_eq("sweep_data", b0.out_data, 4'hA + i);
            check_eq("sweep_chan", b0.out_chan, i);
        end

        // Sparse channels 3 and 1 with ptr at 3.
        vld = 4'b1010;
        tick(); check_eq("sparse_1", b1.out_chan, 2'd1);
        tick(); check_eq("sparse_3", b1.out_chan, 2'd3);
        tick(); check_eq("sparse_1b", b1.out_chan, 2'd1);
        vld = 4'b0000;
        tick(); check_eq("sparse_drain", b1.out_valid, 1'b0);

        // Backpressure
        sel = 2'd1; vld = 4'hF;
        tick(); check_eq("bp_load", b0.out_data, 4'hB);
        ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("bp_hold_data", b0.out_data, 4'hB);
            check_eq("bp_hold_valid", b0.out_valid, 1'b1);
            check_eq("bp_rr_chan", b1.out_chan, 2'd2);
            check_eq("bp_in_ready", {b0.in_ready, b1.in_ready}, 8'h00);
        end
        sel = 2'd2; ordy = 1'b1;
        tick();
        check_eq("bp_resume_sel", b0.out_data, 4'hC);
        check_eq("bp_resume_rr", b1.out_chan, 2'd3);

        // Granted but invalid channel
        vld = 4'b1011;
        #1 check_eq("inv_in_ready", b0.in_ready, 4'b0100);
        tick(); check_eq("inv_drain", b0.out_valid, 1'b0);

        // Out-of-range select on the 3-channel instance
        vld = 4'hF;
        #1 check_eq("oor_in_ready", b3.in_ready, 3'b000);
        tick(); check_eq("oor_valid", b3.out_valid, 1'b0);
        sel3 = 2'd1;
        tick();
        check_eq("c3_data", b3.out_data, 4'hB);
        check_eq("c3_chan", b3.out_chan, 2'd1);
        check_eq("c3_valid", b3.out_valid, 1'b1);

        for (int i = 0; i < 60; i++) begin
            din  = 16'($urandom);
            vld  = 4'($urandom);
            sel  = 2'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Asynchronous reset while a word is held
        vld = 4'hF; ordy = 1'b1; din = 16'h5678;
        tick(); check_eq("pre_arst_valid", b1.out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_valid", {b0.out_valid, b1.out_valid, b3.out_valid}, 3'b000);
        check_eq("arst_data", {b0.out_data, b1.out_data, b3.out_data}, 12'h000);
        check_eq("arst_chan", {b0.out_chan, b1.out_chan, b3.out_chan}, 6'h00);
        tick();
        rst = 1'b0;
        tick();
        check_eq("post_rst_chan", b1.out_chan, 2'd0);
        check_eq("post_rst_data", b1.out_data, 4'h8);
        tick(); tick();
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
